// File: rtl/ram_jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_jk_pkg
// Purpose  : Shared types and constants for the JK-cell scratch RAM.
//            - Sweep state machine encoding (IDLE / SWEEP)
//            - {J,K} control encodings for a JK cell
//            - Address-width helper that stays >= 1 for tiny depths
// Optional : RAM_JK_PARITY_EN (used by ram_jk_array, no effect here)
// Revision : 1.0 - initial release
// ============================================================================
package ram_jk_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // {J,K} pairs driven into a jk_cell.
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;

    // $clog2 returns 0 for depth 1; an address port still needs one bit.
    function automatic int addr_width(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage : ram_jk_pkg
`default_nettype wire

// File: rtl/ram_jk_array_jk_cell.sv
`default_nettype none
// ============================================================================
// Module   : jk_cell
// Purpose  : Single JK flip-flop storage cell with asynchronous clear.
//            J K : 00 hold, 01 reset, 10 set, 11 toggle.
// Ports    : clk    in  rising-edge clock
//            clr_n  in  asynchronous active-low clear (q -> 0)
//            j, k   in  JK controls
//            q      out stored bit
// Revision : 1.0 - initial release
// ============================================================================
module jk_cell (
    input  logic clk,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule : jk_cell
`default_nettype wire

// File: rtl/ram_jk_array.sv
`default_nettype none
// ============================================================================
// Module   : ram_jk_array
// Purpose  : DEPTH x WIDTH scratch RAM built from JK flip-flop cells, with
//            address decode, a registered read port plus valid strobe, a
//            tri-state output bus and a hardware clear-sweep state machine.
// Params   : WIDTH  data bits per word (>= 1)
//            DEPTH  number of words (>= 2, any value)
// Ports    : clk       in   rising-edge clock
//            clr_n     in   asynchronous active-low reset
//            cs        in   chip select
//            rw        in   1 = write, 0 = read
//            addr      in   word address
//            data_in   in   write data
//            oe        in   output enable for data_out
//            init      in   request a clear sweep of the whole array
//            data_out  out  read register, high-Z when oe = 0
//            rd_valid  out  one-cycle strobe after each accepted read
//            busy      out  sweep in progress, accesses ignored
//            par_err   out  parity mismatch on last read (parity build only)
// Optional : RAM_JK_PARITY_EN adds one even-parity cell per word and par_err.
// Revision : 1.0 - initial release
// ============================================================================
module ram_jk_array
    import ram_jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                clr_n,
    input  logic                                cs,
    input  logic                                rw,
    input  logic [ram_jk_pkg::addr_width(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]                    data_in,
    input  logic                                oe,
    input  logic                                init,
    output logic [WIDTH-1:0]                    data_out,
    output logic                                rd_valid,
`ifdef RAM_JK_PARITY_EN
    output logic                                par_err,
`endif
    output logic                                busy
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    state_t                       r_state;
    state_t                       w_state_next;
    logic [ADDR_W-1:0]            r_ptr;
    logic [ADDR_W-1:0]            w_ptr_next;
    logic [WIDTH-1:0]             r_rd_data;
    logic                         r_rd_valid;

    logic [DEPTH-1:0][WIDTH-1:0]  w_mem;
    logic [DEPTH-1:0]             w_sel;
    logic [WIDTH-1:0]             w_rd_word;
    logic                         w_idle;
    logic                         w_wr;
    logic                         w_rd;

    // ------------------------------------------------------------------
    // Access qualification. init takes priority over any access in the
    // same cycle, and nothing is accepted while sweeping.
    // ------------------------------------------------------------------
    assign w_idle = (r_state == IDLE);
    assign w_wr   = w_idle && !init && cs &&  rw;
    assign w_rd   = w_idle && !init && cs && !rw;

    // One-hot word select. An address >= DEPTH matches no word, so such a
    // write touches nothing and such a read returns zero.
    always_comb begin
        w_sel = '0;
        for (int w = 0; w < DEPTH; w++) begin
            w_sel[w] = (addr == ADDR_W'(w));
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if (w_sel[w]) begin
                w_rd_word = w_mem[w];
            end
        end
    end

`ifdef RAM_JK_PARITY_EN
    logic [DEPTH-1:0] w_par;
    logic             w_rd_par;
    logic             w_par_in;
    logic             r_par_err;

    assign w_par_in = ^data_in;

    always_comb begin
        w_rd_par = 1'b0;
        for (int w = 0; w < DEPTH; w++) begin
            if (w_sel[w]) begin
                w_rd_par = w_par[w];
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Cell array. The sweep clear wins over a write; the two cannot
    // coincide anyway because writes are only accepted in IDLE.
    // ------------------------------------------------------------------
    for (genvar gw = 0; gw < DEPTH; gw++) begin : g_word
        logic w_clear;
        logic w_load;

        assign w_clear = (r_state == SWEEP) && (r_ptr == ADDR_W'(gw));
        assign w_load  = w_wr && w_sel[gw];

        for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
            logic [1:0] w_jk;

            assign w_jk = w_clear ? RST :
                          w_load  ? (data_in[gb] ? SET : RST) :
                                    HOLD;

            jk_cell u_cell (
                .clk   (clk),
                .clr_n (clr_n),
                .j     (w_jk[1]),
                .k     (w_jk[0]),
                .q     (w_mem[gw][gb])
            );
        end

`ifdef RAM_JK_PARITY_EN
        logic [1:0] w_pjk;

        assign w_pjk = w_clear ? RST :
                       w_load  ? (w_par_in ? SET : RST) :
                                 HOLD;

        jk_cell u_par (
            .clk   (clk),
            .clr_n (clr_n),
            .j     (w_pjk[1]),
            .k     (w_pjk[0]),
            .q     (w_par[gw])
        );
`endif
    end

    // ------------------------------------------------------------------
    // Sweep state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            IDLE: begin
                if (init) begin
                    w_state_next = SWEEP;
                    w_ptr_next   = '0;
                end
            end
            SWEEP: begin
                // The word at r_ptr is cleared on this edge; leaving after
                // the last word keeps the sweep at exactly DEPTH cycles.
                if (r_ptr == C_LAST) begin
                    w_state_next = IDLE;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next   = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read register and strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (r_state == SWEEP) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd) begin
            r_rd_data  <= w_rd_word;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

`ifdef RAM_JK_PARITY_EN
    // Flag travels with the read strobe; out-of-range reads select no
    // word and therefore never report an error.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_par_err <= 1'b0;
        end else if (r_state == SWEEP) begin
            r_par_err <= 1'b0;
        end else if (w_rd) begin
            r_par_err <= (|w_sel) && ((^w_rd_word) != w_rd_par);
        end else begin
            r_par_err <= 1'b0;
        end
    end

    assign par_err = r_par_err;
`endif

    assign data_out = oe ? r_rd_data : {WIDTH{1'bz}};
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == SWEEP);

endmodule : ram_jk_array
`default_nettype wire

// File: tb/tb_ram_jk_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_jk_array
// Purpose  : Self-checking bench for ram_jk_array. A 4-word instance is the
//            main target; a 3-word instance shares its inputs to exercise
//            out-of-range addresses and a non-power-of-2 sweep length.
// Optional : RAM_JK_PARITY_EN enables the parity-cell sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_jk_array;

    logic       clk     = 1'b0;
    logic       clr_n   = 1'b1;
    logic       cs      = 1'b0;
    logic       rw      = 1'b0;
    logic [1:0] addr    = 2'd0;
    logic [3:0] data_in = 4'h0;
    logic       oe      = 1'b1;
    logic       init    = 1'b0;

    wire  [3:0] data_out;
    wire  [3:0] data_out3;
    logic       rd_valid, busy;
    logic       rd_valid3, busy3;
`ifdef RAM_JK_PARITY_EN
    logic       par_err, par_err3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_jk_array #(.WIDTH(4), .DEPTH(4)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .oe       (oe),
        .init     (init),
        .data_out (data_out),
        .rd_valid (rd_valid),
`ifdef RAM_JK_PARITY_EN
        .par_err  (par_err),
`endif
        .busy     (busy)
    );

    ram_jk_array #(.WIDTH(4), .DEPTH(3)) dut3 (
        .clk      (clk),
        .clr_n    (clr_n),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .oe       (oe),
        .init     (init),
        .data_out (data_out3),
        .rd_valid (rd_valid3),
`ifdef RAM_JK_PARITY_EN
        .par_err  (par_err3),
`endif
        .busy     (busy3)
    );

    typedef struct {
        string      name;
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [3:0] din;
        logic       exp_valid;
        logic [3:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // With oe low the bus must not carry the read register; a 2-state
    // simulator may resolve an undriven bus to 0, so both are accepted.
    task automatic check_hiz(input string name, input logic [3:0] act);
        checks++;
        if (!(act === 4'bzzzz || act === 4'b0000)) begin
            failures++;
            $display("FAIL %s: got %b expected zzzz", name, act);
        end
    endtask

    task automatic step(input logic c, input logic r, input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        cs      = c;
        rw      = r;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic c, input logic r,
                                input logic [1:0] a, input logic [3:0] d,
                                input logic ev, input logic [3:0] ed);
        vec_t v;
        v.name = n; v.cs = c; v.rw = r; v.addr = a; v.din = d;
        v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ------------------------------------------------ table
        tbl.push_back(mk("rst_rd0", 1, 0, 2'd0, 4'h0, 1, 4'h0));
        tbl.push_back(mk("rst_rd1", 1, 0, 2'd1, 4'h0, 1, 4'h0));
        tbl.push_back(mk("rst_rd2", 1, 0, 2'd2, 4'h0, 1, 4'h0));
        tbl.push_back(mk("rst_rd3", 1, 0, 2'd3, 4'h0, 1, 4'h0));
        tbl.push_back(mk("wr0_A",   1, 1, 2'd0, 4'hA, 0, 4'h0));
        tbl.push_back(mk("wr1_5",   1, 1, 2'd1, 4'h5, 0, 4'h0));
        tbl.push_back(mk("wr2_F",   1, 1, 2'd2, 4'hF, 0, 4'h0));
        tbl.push_back(mk("wr3_3",   1, 1, 2'd3, 4'h3, 0, 4'h0));
        tbl.push_back(mk("rd3",     1, 0, 2'd3, 4'h0, 1, 4'h3));
        tbl.push_back(mk("rd2",     1, 0, 2'd2, 4'h0, 1, 4'hF));
        tbl.push_back(mk("rd1",     1, 0, 2'd1, 4'h0, 1, 4'h5));
        tbl.push_back(mk("rd0",     1, 0, 2'd0, 4'h0, 1, 4'hA));
        tbl.push_back(mk("idle",    0, 0, 2'd0, 4'h0, 0, 4'hA));
        tbl.push_back(mk("wr2_6",   1, 1, 2'd2, 4'h6, 0, 4'hA));
        tbl.push_back(mk("rd2_new", 1, 0, 2'd2, 4'h0, 1, 4'h6));

        // ------------------------------------------------ async reset
        #1 clr_n = 1'b0;
        #2;
        check("reset_busy",     busy,     1'b0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_data",     data_out, 4'h0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].cs, tbl[i].rw, tbl[i].addr, tbl[i].din);
            check({tbl[i].name, "_valid"}, rd_valid, tbl[i].exp_valid);
            check({tbl[i].name, "_data"},  data_out, tbl[i].exp_data);
            check({tbl[i].name, "_busy"},  busy,     1'b0);
        end

        // ------------------------------------------------ oe low mid-read
        @(negedge clk);
        oe = 1'b0;
        step(1, 0, 2'd2, 4'h0);
        check("oe0_valid", rd_valid, 1'b1);
        check_hiz("oe0_data", data_out);
        oe = 1'b1;
        #1;
        check("oe1_data", data_out, 4'h6);
        step(0, 0, 2'd0, 4'h0);
        check("oe1_valid_drop", rd_valid, 1'b0);

        // ------------------------------------------------ out of range (DEPTH=3)
        step(1, 1, 2'd2, 4'h5);
        step(1, 1, 2'd3, 4'hF);
        step(1, 0, 2'd3, 4'h0);
        check("oor_valid", rd_valid3, 1'b1);
        check("oor_data",  data_out3, 4'h0);
        step(1, 0, 2'd2, 4'h0);
        check("oor_no_alias", data_out3, 4'h5);

        // ------------------------------------------------ sweep
        for (int a = 0; a < 4; a++) step(1, 1, 2'(a), 4'hF);
        step(1, 0, 2'd1, 4'h0);
        check("pre_sweep_data", data_out, 4'hF);
        @(negedge clk);
        init = 1'b1; cs = 1'b1; rw = 1'b1; addr = 2'd0; data_in = 4'h1;
        @(posedge clk);
        #1;
        check("sweep_start_busy",  busy,     1'b1);
        check("sweep_start_valid", rd_valid, 1'b0);
        @(negedge clk);
        init = 1'b0; rw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d_busy", i),  busy,     1'b1);
            check($sformatf("sweep%0d_valid", i), rd_valid, 1'b0);
            check($sformatf("sweep%0d_data", i),  data_out, 4'h0);
            check($sformatf("sweep3w%0d_busy", i), busy3, (i < 2) ? 1'b1 : 1'b0);
        end
        @(posedge clk);
        #1;
        check("sweep_end_busy",  busy,     1'b0);
        check("sweep_end_valid", rd_valid, 1'b0);
        for (int a = 3; a >= 0; a--) begin
            step(1, 0, 2'(a), 4'h0);
            check($sformatf("post_sweep_rd%0d", a), data_out, 4'h0);
            check($sformatf("post_sweep_v%0d", a),  rd_valid, 1'b1);
        end

        // ------------------------------------------------ reset mid-sweep
        step(1, 1, 2'd3, 4'h5);
        step(1, 0, 2'd3, 4'h0);
        check("pre_abort_data", data_out, 4'h5);
        @(negedge clk);
        init = 1'b1; cs = 1'b0;
        @(negedge clk);
        init = 1'b0;
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("abort_busy",  busy,     1'b0);
        check("abort_valid", rd_valid, 1'b0);
        check("abort_data",  data_out, 4'h0);
        @(negedge clk);
        clr_n = 1'b1;
        step(1, 0, 2'd3, 4'h0);
        check("abort_rd3_valid", rd_valid, 1'b1);
        check("abort_rd3_data",  data_out, 4'h0);
        check("abort_rd3_busy",  busy,     1'b0);

`ifdef RAM_JK_PARITY_EN
        // ------------------------------------------------ parity
        step(1, 1, 2'd1, 4'h7);
        step(1, 1, 2'd0, 4'h3);
        force dut.g_word[1].u_par.q = 1'b0;
        step(1, 0, 2'd1, 4'h0);
        check("par_bad_data", data_out, 4'h7);
        check("par_bad_err",  par_err,  1'b1);
        release dut.g_word[1].u_par.q;
        step(1, 0, 2'd0, 4'h0);
        check("par_ok_data", data_out, 4'h3);
        check("par_ok_err",  par_err,  1'b0);
`endif

        step(0, 0, 2'd0, 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ram_jk_array
`default_nettype wire

// File: doc/ram_jk_array.md
Name: ram_jk_array

Overview:
- Parametrised successor to the team's 1-word JK-cell RAM: DEPTH words x WIDTH bits.
- Every bit is stored in a JK flip-flop cell. Writes drive J=data, K=~data into the addressed word only.
- Adds address decode, a registered read port with a valid strobe, a tri-state output bus, and a hardware clear-sweep state machine.
- Sits on the shared data bus of the lab datapath as a small scratch memory.

Parameters:
- WIDTH, 4, data bits per word (>=1).
- DEPTH, 4, number of words (>=2; need not be a power of 2).
- ADDR_W, derived localparam = $clog2(DEPTH); not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- cs  in  1  chip select; an access happens only when cs=1.
- rw  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  word address.
- data_in  in  WIDTH  write data.
- oe  in  1  output enable for the tri-state bus.
- init  in  1  request a clear sweep of the whole array.
- data_out  out  WIDTH  read data register; high-Z when oe=0.
- rd_valid  out  1  one-cycle strobe: data_out was updated by a read.
- busy  out  1  sweep in progress; accesses are ignored.

Behaviour:
- Reset (clr_n=0, async, no clock needed):
  - all cells = 0
  - read register = 0, rd_valid = 0, busy = 0
  - state = IDLE, sweep pointer = 0
  - data_out = 0 if oe=1, else Z
- Cell control is JK-based, not a plain register write:
  - selected word: J=data_in[i], K=~data_in[i]
  - unselected words: J=K=0 (hold)
  - toggle (J=K=1) never occurs in normal operation
- Write: cs=1, rw=1 in IDLE at edge n.
  - mem[addr] = data_in after edge n.
  - No read strobe; read register unchanged.
- Read: cs=1, rw=0 in IDLE at edge n.
  - Read register = mem[addr] as sampled at edge n (1-cycle latency).
  - rd_valid=1 for exactly the cycle after edge n.
  - Back-to-back reads give back-to-back strobes.
- Write at edge n then read of the same address at edge n+1 returns the new data.
- The read register holds its value until the next read, sweep, or reset.
- Out-of-range address (addr >= DEPTH):
  - write is ignored; no cell changes
  - read loads 0 and still pulses rd_valid
- Tri-state output:
  - data_out = read register when oe=1, else Z
  - oe is combinational and does not affect state
- State machine has two states, IDLE and SWEEP.
  - IDLE -> SWEEP: init=1 at an edge. Pointer = 0, busy=1 from the next cycle.
  - If init and cs are both 1 in the same cycle, init wins and the access is dropped.
  - In SWEEP, each edge applies J=0, K=1 to word[pointer], then pointer++.
  - After word DEPTH-1 is cleared, go to IDLE and busy=0. The sweep occupies exactly DEPTH cycles.
  - In SWEEP: cs, rw and init are ignored, rd_valid=0, and the read register is also cleared to 0.
- Reset during SWEEP aborts immediately: all cells are 0 anyway, state = IDLE.

Optional Feature:
- Macro: RAM_JK_PARITY_EN.
- When defined:
  - Each word stores one extra JK cell holding even parity of data_in on write.
  - Sweep clears the parity cell too; reset leaves it at 0.
  - Added output par_err (1 bit). On a read it is registered alongside rd_valid: par_err=1 if the stored parity mismatches the stored data.
  - par_err=0 on out-of-range reads and on reset.
- When not defined: no parity storage and no par_err port.

Decomposition:
- Package ram_jk_pkg holds:
  - state enum {IDLE, SWEEP}
  - J/K encoding constants HOLD=2'b00, RST=2'b01, SET=2'b10
  - a clog2-safe address-width function
- Sub-module jk_cell: a single JK flip-flop with async active-low clear, instantiated WIDTH*DEPTH times (plus DEPTH parity cells) via generate loops.
- Decode, FSM and read register stay in the top module.

Test Plan:
- Reset, then read all 4 addresses with oe=1 -> each read returns 4'h0 with one rd_valid pulse; busy=0.
- Write A0=4'hA, A1=4'h5, A2=4'hF, A3=4'h3; read back in reverse order -> 3, F, 5, A, each one cycle after its request.
- Write A2=4'h6 then read A2 on the next cycle -> 4'h6. Toggle oe=0 mid-read -> data_out=ZZZZ, rd_valid still pulses.
- Fill all words with 4'hF, assert init together with cs=1/rw=1 writing A0=4'h1:
  - write is dropped
  - busy high for 4 cycles and reads are ignored
  - afterwards all words read 4'h0
- Start a sweep, pull clr_n low on cycle 2 -> busy=0 and all outputs reset immediately; after release, a read of A3 returns 0.
- RAM_JK_PARITY_EN defined, write A1=4'h7, force the parity cell to flip -> read A1 gives data 4'h7 with par_err=1; a clean word gives par_err=0.
